candidate_block_streamer: RTL and testbench

Parametrised successor to the fixed 64-wide, 4x4, combinational window/frame memory. It holds a FRAME_W x FRAME_H frame of PIX_W-bit pixels and, on start, walks every BLK x BLK candidate position in raster order. It emits one BLK-pixel candidate row per beat over a valid/ready handshake. The SAD datapath consumes these rows, so it no longer needs to decode a 100-pixel strip itself.

---
 rtl/candidate_stream_pkg.sv | 19 +
 rtl/frame_row_ram.sv | 47 ++++
 rtl/candidate_block_streamer.sv | 157 +++++++++++++++
 tb/tb_candidate_block_streamer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candidate_stream_pkg.sv
// Shared types and derived-size helpers for the candidate block streamer.
// Candidate counts depend on the frame/block parameters, so they are exposed as constant functions.
package candidate_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int num_cand(input int frame_dim, input int blk);
        return frame_dim - blk + 1;
    endfunction

    function automatic int beats_per_scan(input int frame_w, input int frame_h, input int blk);
        return num_cand(frame_w, blk) * num_cand(frame_h, blk) * blk;
    endfunction

endpackage

// File: rtl/frame_row_ram.sv
// Frame pixel store: synchronous single-pixel write, combinational BLK-pixel row read.
// A write landing inside the row being read is forwarded so the reader sees the new value this cycle.
module frame_row_ram #(
    parameter int PIX_W   = 9,
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int BLK     = 4,
    parameter int ADDR_W  = 12
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [PIX_W-1:0]       i_wr_data,
    input  logic [ADDR_W:0]        i_rd_addr,
    output logic [BLK*PIX_W-1:0]   o_rd_row
);

    localparam int DEPTH = FRAME_W * FRAME_H;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_W + 1;

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    // Out-of-range writes are dropped rather than aliased onto low addresses.
    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < AW1'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_row = '0;
        for (int k = 0; k < BLK; k++) begin
            logic [AW1-1:0] w_addr_k;
            w_addr_k = i_rd_addr + AW1'(k);
            if (w_wr_ok && ({1'b0, i_wr_addr} == w_addr_k)) begin
                o_rd_row[k*PIX_W +: PIX_W] = i_wr_data;
            end else if (w_addr_k < AW1'(DEPTH)) begin
                o_rd_row[k*PIX_W +: PIX_W] = r_mem[w_addr_k[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/candidate_block_streamer.sv
// Walks every BLK x BLK candidate of the stored frame in raster order and streams one
// candidate row per beat over valid/ready; holds the frame, scan FSM, counters and output register.
module candidate_block_streamer
    import candidate_stream_pkg::*;
#(
    parameter int PIX_W   = 9,
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int BLK     = 4,
    parameter int ADDR_W  = 12,
    parameter int COORD_W = 6
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLK*PIX_W-1:0]   out_row,
    output logic [COORD_W-1:0]     out_x,
    output logic [COORD_W-1:0]     out_y,
    output logic [COORD_W-1:0]     out_r,
    output logic                   out_last_row,
    output logic                   out_last
);

    localparam int NUM_CAND_X = num_cand(FRAME_W, BLK);
    localparam int NUM_CAND_Y = num_cand(FRAME_H, BLK);
    localparam int AW1        = ADDR_W + 1;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(NUM_CAND_X - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(NUM_CAND_Y - 1);
    localparam logic [COORD_W-1:0] R_MAX = COORD_W'(BLK - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COORD_W-1:0]     r_x, r_y, r_r;
    logic [BLK*PIX_W-1:0]   r_row;
    logic                   r_valid;

    logic [COORD_W-1:0]     w_nx, w_ny, w_nr;
    logic                   w_load, w_end, w_fire, w_is_last, w_wr_en;
    logic [AW1-1:0]         w_rd_addr;
    logic [BLK*PIX_W-1:0]   w_rd_row;

    // Valid/ready: a beat transfers on a rising edge where out_valid && out_ready; while
    // out_valid is high without ready, the row and every tag hold and out_valid cannot fall.
    assign w_fire    = r_valid && out_ready;
    assign w_is_last = (r_x == X_MAX) && (r_y == Y_MAX) && (r_r == R_MAX);
    assign w_wr_en   = wr_en && (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_end       = 1'b0;
        w_nx        = r_x;
        w_ny        = r_y;
        w_nr        = r_r;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_STREAM;
                    w_load      = 1'b1;
                    w_nx        = '0;
                    w_ny        = '0;
                    w_nr        = '0;
                end
            end
            ST_STREAM: begin
                if (w_fire) begin
                    if (w_is_last) begin
                        w_state_nxt = ST_DONE;
                        w_end       = 1'b1;
                    end else begin
                        w_load = 1'b1;
                        if (r_r == R_MAX) begin
                            w_nr = '0;
                            if (r_x == X_MAX) begin
                                w_nx = '0;
                                w_ny = r_y + COORD_W'(1);
                            end else begin
                                w_nx = r_x + COORD_W'(1);
                            end
                        end else begin
                            w_nr = r_r + COORD_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The read address tracks the position being loaded, so the next row is ready the same cycle.
    assign w_rd_addr = (AW1'(w_ny) + AW1'(w_nr)) * AW1'(FRAME_W) + AW1'(w_nx);

    frame_row_ram #(
        .PIX_W   (PIX_W),
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .BLK     (BLK),
        .ADDR_W  (ADDR_W)
    ) u_ram (
        .i_clk     (Clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_row  (w_rd_row)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_r     <= w_nr;
            r_row   <= w_rd_row;
            r_valid <= 1'b1;
        end else if (w_end) begin
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign busy         = (r_state == ST_STREAM);
    assign done         = (r_state == ST_DONE);
    assign out_valid    = r_valid;
    assign out_row      = r_row;
    assign out_x        = r_x;
    assign out_y        = r_y;
    assign out_r        = r_r;
    assign out_last_row = r_valid && (r_r == R_MAX);
    assign out_last     = r_valid && w_is_last;

endmodule

// File: tb/tb_candidate_block_streamer.sv
// Self-checking bench for candidate_block_streamer on an 8x8 frame with 4x4 candidates.
// Expected beats come from a raster-order walk over a pixel array mirroring the frame.
module tb_candidate_block_streamer;

    localparam int PIX_W   = 9;
    localparam int FRAME_W = 8;
    localparam int FRAME_H = 8;
    localparam int BLK     = 4;
    localparam int ADDR_W  = 7;
    localparam int COORD_W = 4;
    localparam int NCX     = FRAME_W - BLK + 1;
    localparam int NCY     = FRAME_H - BLK + 1;
    localparam int BEATS   = NCX * NCY * BLK;
    localparam int DEPTH   = FRAME_W * FRAME_H;
    localparam int ROW_W   = BLK * PIX_W;
    localparam int EXP_W   = ROW_W + 3 * COORD_W + 2;
    localparam int BUDGET  = 2000;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 wr_en = 1'b0;
    logic [ADDR_W-1:0]    wr_addr = '0;
    logic [PIX_W-1:0]     wr_data = '0;
    logic                 start = 1'b0;
    logic                 busy, done, out_valid;
    logic                 out_ready = 1'b0;
    logic [ROW_W-1:0]     out_row;
    logic [COORD_W-1:0]   out_x, out_y, out_r;
    logic                 out_last_row, out_last;

    logic [PIX_W-1:0]     model_mem [DEPTH];
    logic [EXP_W-1:0]     exp_q[$];
    logic [EXP_W-1:0]     last_obs;
    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   scan_beats, scan_gaps, scan_cycles;

    candidate_block_streamer #(
        .PIX_W(PIX_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
        .BLK(BLK), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_x(out_x), .out_y(out_y), .out_r(out_r),
        .out_last_row(out_last_row), .out_last(out_last)
    );

    always #5 Clk = ~Clk;

    function automatic logic [EXP_W-1:0] pack_beat(input logic [ROW_W-1:0] row, input int x,
                                                   input int y, input int r, input bit lr, input bit l);
        return {row, COORD_W'(x), COORD_W'(y), COORD_W'(r), lr, l};
    endfunction

    function automatic logic [EXP_W-1:0] observed();
        return {out_row, out_x, out_y, out_r, out_last_row, out_last};
    endfunction

    function automatic logic [ROW_W+3*COORD_W+4:0] all_outputs();
        return {busy, done, out_valid, out_row, out_x, out_y, out_r, out_last_row, out_last};
    endfunction

    // Reference: every candidate (x,y) in raster order, each contributing BLK rows.
    task automatic build_expected();
        logic [ROW_W-1:0] row;
        exp_q.delete();
        for (int y = 0; y < NCY; y++)
            for (int x = 0; x < NCX; x++)
                for (int r = 0; r < BLK; r++) begin
                    for (int k = 0; k < BLK; k++)
                        row[k*PIX_W +: PIX_W] = model_mem[(y + r) * FRAME_W + x + k];
                    exp_q.push_back(pack_beat(row, x, y, r, r == BLK - 1,
                                              (x == NCX - 1) && (y == NCY - 1) && (r == BLK - 1)));
                end
    endtask

    task automatic write_px(input int addr, input int data);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = PIX_W'(data);
        @(posedge Clk); #1;
        wr_en = 1'b0;
        if (addr < DEPTH) model_mem[addr] = PIX_W'(data);
    endtask

    task automatic load_frame(input bit random_px);
        for (int a = 0; a < DEPTH; a++)
            write_px(a, random_px ? int'($urandom_range(0, (1 << PIX_W) - 1)) : a);
    endtask

    task automatic do_start(input bit with_wr, input int addr, input int data);
        start = 1'b1;
        wr_en = with_wr;
        wr_addr = ADDR_W'(addr);
        wr_data = PIX_W'(data);
        if (with_wr && addr < DEPTH) model_mem[addr] = PIX_W'(data);
        build_expected();
        @(posedge Clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_beat_latency: valid=%b busy=%b required valid=1 busy=1", out_valid, busy);
        end
    endtask

    // mode 0: ready held high; 1: random ready; 2: 3-cycle stall on beat 7.
    // poke_kind 1 pulses start, 2 issues a write (addr 1, data 0), once beats==poke_at.
    task automatic run_scan(input int mode, input int stop_after, input int poke_kind, input int poke_at);
        int beats, gaps, stall, cyc;
        bit poked, holding, rdy;
        logic [EXP_W-1:0] held, obs, exp_v;
        beats = 0; gaps = 0; stall = 0; poked = 0; holding = 0; held = '0;
        for (cyc = 0; cyc < BUDGET && beats < stop_after; cyc++) begin
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && beats == 6 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end
            out_ready = rdy;
            start = 1'b0;
            wr_en = 1'b0;
            if (!poked && poke_kind != 0 && beats == poke_at) begin
                poked = 1'b1;
                if (poke_kind == 1) start = 1'b1;
                else begin
                    wr_en = 1'b1;
                    wr_addr = ADDR_W'(1);
                    wr_data = '0;
                end
            end
            obs = observed();
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_in_scan: beat %0d busy=%b required 1", beats, busy);
            end
            if (holding) begin
                n_checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: beat %0d valid=%b got %h required %h", beats, out_valid, obs, held);
                end
            end
            holding = 1'b0;
            if (out_valid === 1'b1) begin
                if (rdy) begin
                    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    n_checks++;
                    if (obs !== exp_v) begin
                        n_fail++;
                        $display("FAIL beat_%0d: got %h required %h", beats, obs, exp_v);
                    end
                    last_obs = obs;
                    beats++;
                end else begin
                    holding = 1'b1;
                    held = obs;
                end
            end else begin
                gaps++;
            end
            @(posedge Clk); #1;
        end
        start = 1'b0;
        wr_en = 1'b0;
        scan_beats = beats;
        scan_gaps = gaps;
        scan_cycles = cyc;
        n_checks++;
        if (beats != stop_after) begin
            n_fail++;
            $display("FAIL scan_timeout: beats %0d required %0d", beats, stop_after);
        end
    endtask

    task automatic check_done_tail(input bit poke_start);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b required 1 0 0", done, busy, out_valid);
        end
        start = poke_start;
        @(posedge Clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b required 0", done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_done: busy=%b valid=%b done=%b required 0 0 0", busy, out_valid, done);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (all_outputs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outputs());
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
        n_checks++;
        if (all_outputs() !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h required 0", all_outputs());
        end
    endtask

    task automatic test_first_beats_and_full_scan();
        logic [ROW_W-1:0] row;
        load_frame(1'b0);
        do_start(1'b0, 0, 0);
        for (int k = 0; k < BLK; k++) row[k*PIX_W +: PIX_W] = PIX_W'(k);
        n_checks++;
        if (observed() !== pack_beat(row, 0, 0, 0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL first_beat: got %h required %h", observed(), pack_beat(row, 0, 0, 0, 1'b0, 1'b0));
        end
        out_ready = 1'b1;
        run_scan(0, BEATS, 0, 0);
        n_checks++;
        if (scan_gaps != 0 || scan_cycles != BEATS) begin
            n_fail++;
            $display("FAIL no_bubbles: gaps %0d cycles %0d required 0 %0d", scan_gaps, scan_cycles, BEATS);
        end
        for (int k = 0; k < BLK; k++) row[k*PIX_W +: PIX_W] = PIX_W'(60 + k);
        n_checks++;
        if (last_obs !== pack_beat(row, 4, 4, 3, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL final_beat: got %h required %h", last_obs, pack_beat(row, 4, 4, 3, 1'b1, 1'b1));
        end
        check_done_tail(1'b0);
    endtask

    task automatic test_backpressure();
        do_start(1'b0, 0, 0);
        run_scan(2, BEATS, 0, 0);
        n_checks++;
        if (scan_cycles != BEATS + 3) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d required %0d", scan_cycles, BEATS + 3);
        end
        check_done_tail(1'b0);
    endtask

    task automatic test_random_ready();
        load_frame(1'b1);
        do_start(1'b0, 0, 0);
        run_scan(1, BEATS, 0, 0);
        check_done_tail(1'b0);
    endtask

    task automatic test_write_forward();
        load_frame(1'b0);
        write_px(64, 'h0AA);
        write_px(127, 'h155);
        do_start(1'b1, 0, 'h1FF);
        n_checks++;
        if (out_row[PIX_W-1:0] !== 9'h1FF) begin
            n_fail++;
            $display("FAIL forward_pixel0: got %h required 1ff", out_row[PIX_W-1:0]);
        end
        run_scan(0, BEATS, 2, 10);
        check_done_tail(1'b0);
        do_start(1'b0, 0, 0);
        run_scan(1, BEATS, 0, 0);
        check_done_tail(1'b0);
    endtask

    task automatic test_reset_mid_scan();
        do_start(1'b0, 0, 0);
        run_scan(0, 39, 0, 0);
        Reset = 1'b1;
        #1;
        n_checks++;
        if (all_outputs() !== '0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %h required 0", all_outputs());
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_done_after_reset: done=%b busy=%b valid=%b required 0 0 0", done, busy, out_valid);
            end
        end
        do_start(1'b0, 0, 0);
        run_scan(0, BEATS, 0, 0);
        check_done_tail(1'b0);
    endtask

    task automatic test_start_ignored();
        do_start(1'b0, 0, 0);
        run_scan(1, BEATS, 1, 20);
        check_done_tail(1'b1);
    endtask

    initial begin
        test_reset();
        test_first_beats_and_full_scan();
        test_backpressure();
        test_random_ready();
        test_write_forward();
        test_reset_mid_scan();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
